// File: rtl/param_data_memory.sv
// param_data_memory: parametrised single-port data memory with byte-lane writes,
// a valid/ready request port, a registered one-cycle read response and a
// built-in clear engine that zeroes the array one word per cycle.
module param_data_memory #(
    parameter int unsigned        DATA_W        = 8,
    parameter int unsigned        ADDR_W        = 8,
    parameter int unsigned        DEPTH         = 256,
    parameter logic [DATA_W-1:0]  CLEAR_VAL     = '0,
    parameter bit                 INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  err_oob,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Counter is one bit wider than the address so DEPTH == 2**ADDR_W is representable.
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_clr_cnt;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_err_oob;
    logic                  r_clr_done;

    // Storage array; intentionally not reset, the clear engine initialises it.
    logic [DATA_W-1:0]     r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_req_idx;
    logic [IDX_W-1:0]      w_clr_idx;

    // Request handshake: clr_start takes priority over a simultaneous request.
    assign req_ready  = (r_state == ST_IDLE) && !clr_start;
    assign w_accept   = req_valid && req_ready;
    assign w_in_range = {1'b0, req_addr} < DEPTH_C;
    assign w_wr_en    = w_accept && req_we && w_in_range;
    assign w_req_idx  = IDX_W'(req_addr);
    assign w_clr_idx  = IDX_W'(r_clr_cnt);

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign err_oob    = r_err_oob;
    assign clr_busy   = (r_state == ST_CLEAR);
    assign clr_done   = r_clr_done;

    // Control FSM, clear counter and registered response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= INIT_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_clr_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_err_oob   <= 1'b0;
            r_clr_done  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_err_oob   <= 1'b0;
            r_clr_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clr_start) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end else if (req_valid) begin
                        if (w_in_range) begin
                            if (!req_we) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_rdata <= r_mem[w_req_idx];
                            end
                        end else begin
                            // Out-of-range: writes dropped, reads return zero.
                            r_err_oob <= 1'b1;
                            if (!req_we) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_rdata <= '0;
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == LAST_C) begin
                        r_state    <= ST_IDLE;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_clr_cnt  <= r_clr_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Array write port: clear engine owns it while clearing, else byte-lane writes.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[w_clr_idx] <= CLEAR_VAL;
        end else if (w_wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    r_mem[w_req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_param_data_memory.sv
// Testbench for param_data_memory: directed vector table, hand-written clear and
// reset sequences, and randomized traffic against a behavioural model.
module tb_param_data_memory;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 200;
    localparam logic [31:0] CLR_V  = 32'h0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        err_oob;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;

    param_data_memory #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .DEPTH         (DEPTH),
        .CLEAR_VAL     (CLR_V),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .err_oob   (err_oob),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: word array plus number of clear cycles still to run.
    logic [31:0] mm [256];
    int          m_left;
    logic        e_rv, e_err, e_done, e_busy;
    logic [31:0] e_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; checks DUT against the model after the edge.
    task automatic cycle(input logic v, input logic we, input logic [7:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input logic clr,
                         output logic o_v, output logic [31:0] o_rd,
                         output logic o_err, output logic o_done);
        logic exp_ready;
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        clr_start = clr;
        #1;
        exp_ready = (m_left == 0) && !clr;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        e_rv = 1'b0; e_err = 1'b0; e_done = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                e_done = 1'b1;
                for (int i = 0; i < int'(DEPTH); i++) mm[i] = CLR_V;
            end
        end else if (clr) begin
            m_left = DEPTH;
        end else if (v) begin
            if (int'(a) < int'(DEPTH)) begin
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mm[a][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    e_rv = 1'b1;
                    e_rd = mm[a];
                end
            end else begin
                e_err = 1'b1;
                if (!we) begin
                    e_rv = 1'b1;
                    e_rd = 32'h0;
                end
            end
        end
        e_busy = (m_left > 0);
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("err_oob",   32'(err_oob),   32'(e_err));
        chk("clr_busy",  32'(clr_busy),  32'(e_busy));
        chk("clr_done",  32'(clr_done),  32'(e_done));
        o_v = rsp_valid; o_rd = rsp_rdata; o_err = err_oob; o_done = clr_done;
    endtask

    task automatic idle(output logic o_done);
        logic v, er;
        logic [31:0] rd;
        cycle(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0, v, rd, er, o_done);
    endtask

    // Assert reset now, check outputs immediately, release after the next rising edge.
    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; clr_start = 1'b0;
        #1;
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst err_oob",   32'(err_oob),   32'd0);
        chk("rst clr_done",  32'(clr_done),  32'd0);
        chk("rst clr_busy",  32'(clr_busy),  32'd1);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        m_left = DEPTH;
        e_rd   = 32'h0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_v;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic        ov, oerr, odone;
        logic [31:0] ord;
        int          pulses;
        int          done_at;

        tbl[0]  = '{1'b0, 8'd199, 32'h0,        4'hF, 1'b1, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b1, 8'd5,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 8'd5,   32'h000000AA, 4'h1, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 8'd5,   32'h0,        4'h0, 1'b1, 32'hDEADBEAA, 1'b0};
        tbl[4]  = '{1'b1, 8'd7,   32'h11223344, 4'hF, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 8'd7,   32'h0,        4'h0, 1'b1, 32'h11223344, 1'b0};
        tbl[6]  = '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 32'h00000000, 1'b0};
        tbl[7]  = '{1'b0, 8'd1,   32'h0,        4'h0, 1'b1, 32'h00000000, 1'b0};
        tbl[8]  = '{1'b0, 8'd2,   32'h0,        4'h0, 1'b1, 32'h00000000, 1'b0};
        tbl[9]  = '{1'b1, 8'd210, 32'h00001234, 4'hF, 1'b0, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 8'd10,  32'h0,        4'h0, 1'b1, 32'h00000000, 1'b0};
        tbl[11] = '{1'b0, 8'd255, 32'h0,        4'h0, 1'b1, 32'h00000000, 1'b1};
        tbl[12] = '{1'b1, 8'd9,   32'hFFFFFFFF, 4'h0, 1'b0, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 8'd9,   32'h0,        4'h0, 1'b1, 32'h00000000, 1'b0};
        tbl[14] = '{1'b1, 8'd6,   32'hCAFEF00D, 4'hA, 1'b0, 32'h0,        1'b0};

        reset_n = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; clr_start = 1'b0;
        m_left = 0; e_rd = 32'h0;
        #2;

        // Power-up reset and automatic clear: exactly DEPTH busy cycles, one done pulse.
        do_reset();
        pulses = 0; done_at = -1;
        for (int i = 0; i < int'(DEPTH) + 5; i++) begin
            idle(odone);
            if (odone) begin
                pulses++;
                if (done_at < 0) done_at = i;
            end
        end
        chk("init clr_done pulses", 32'(pulses), 32'd1);
        chk("init clr_done cycle", 32'(done_at), 32'(DEPTH - 1));

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b0,
                  ov, ord, oerr, odone);
            chk($sformatf("vec%0d valid", i), 32'(ov), 32'(tbl[i].exp_v));
            chk($sformatf("vec%0d err", i),   32'(oerr), 32'(tbl[i].exp_err));
            if (tbl[i].exp_v) chk($sformatf("vec%0d rdata", i), ord, tbl[i].exp_rd);
        end

        // clr_start with a simultaneous read: request refused, clear runs DEPTH cycles,
        // a mid-clear clr_start does not extend it.
        cycle(1'b1, 1'b0, 8'd5, 32'h0, 4'h0, 1'b1, ov, ord, oerr, odone);
        chk("clr+req no rsp", 32'(ov), 32'd0);
        pulses = 0; done_at = -1;
        for (int i = 0; i < int'(DEPTH) + 3; i++) begin
            cycle(1'b0, 1'b0, 8'd0, 32'h0, 4'h0, (i == 100), ov, ord, oerr, odone);
            if (odone) begin
                pulses++;
                if (done_at < 0) done_at = i;
            end
        end
        chk("clr pulses", 32'(pulses), 32'd1);
        chk("clr done cycle", 32'(done_at), 32'(DEPTH - 1));
        cycle(1'b1, 1'b0, 8'd5, 32'h0, 4'h0, 1'b0, ov, ord, oerr, odone);
        chk("addr5 after clear", ord, 32'h0);

        // Reset at clear cycle 50: immediate reset values, then one full clear.
        cycle(1'b1, 1'b1, 8'd3, 32'h55AA55AA, 4'hF, 1'b0, ov, ord, oerr, odone);
        cycle(1'b0, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, ov, ord, oerr, odone);
        for (int i = 0; i < 50; i++) idle(odone);
        @(posedge clk);
        #3;
        do_reset();
        pulses = 0; done_at = -1;
        for (int i = 0; i < int'(DEPTH) + 5; i++) begin
            idle(odone);
            if (odone) begin
                pulses++;
                if (done_at < 0) done_at = i;
            end
        end
        chk("rst clr pulses", 32'(pulses), 32'd1);
        chk("rst clr done cycle", 32'(done_at), 32'(DEPTH - 1));

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic        v, we, clr;
            logic [7:0]  a;
            clr = ($urandom_range(0, 149) == 0);
            v   = ($urandom_range(0, 3) != 0);
            we  = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, DEPTH - 1));
            cycle(v, we, a, $urandom, 4'($urandom_range(0, 15)), clr,
                  ov, ord, oerr, odone);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
